// File: rtl/coreboard1588_bram_arb.sv
// coreboard1588_bram_arb
// Arbitrates the ADS868x (s00) and ADS124x (s01) sample streams into the
// shared 16-bit acquisition BRAM. Each accepted sample is stamped with the
// RTC nanosecond count and stored as a 4-word record in a per-channel
// ping-pong buffer. irq pulses once each time a buffer fills.
//
// Handshake: a source transfers a sample in the cycle where its tvalid and
// tready are both high. tready is driven combinationally only in IDLE while
// enabled and out of reset, and only for the granted channel. The source
// must hold tdata stable while tvalid is high and tready is low.
module coreboard1588_bram_arb #(
  parameter int C_REC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_enable,
  input  logic [3:0]             ctrl_release,
  input  logic [31:0]            s00_axis_tdata,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic [31:0]            s01_axis_tdata,
  input  logic                   s01_axis_tvalid,
  output logic                   s01_axis_tready,
  input  logic [31:0]            rtc_nanosecond,
  output logic [C_REC_WIDTH+3:0] bram_addr,
  output logic                   bram_en,
  output logic [1:0]             bram_we,
  output logic [15:0]            bram_din,
  output logic                   irq,
  output logic [3:0]             stat_full,
  output logic [15:0]            stat_drop_cnt0,
  output logic [15:0]            stat_drop_cnt1
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   last_grant;
  logic                   cur_ch;
  logic [31:0]            cap_data;
  logic [31:0]            cap_ns;
  logic [1:0]             wr_buf;
  logic [C_REC_WIDTH-1:0] rec [2];

  logic [1:0] req;
  logic       accept;
  logic       gnt_ch;
  logic [1:0] tgt_idx;
  logic       tgt_full;
  logic       rec_last;
  logic [1:0] done_idx;
  logic [3:0] set_mask;
  logic [1:0] word;

  // Grant: sole requester wins; on a tie the channel not granted last time.
  // A dropped sample still counts as that channel's turn.
  always_comb begin
    req      = {s01_axis_tvalid, s00_axis_tvalid};
    accept   = (state == IDLE) && ctrl_enable && (|req) && !rst;
    gnt_ch   = (req == 2'b11) ? ~last_grant : req[1];
    tgt_idx  = {gnt_ch, wr_buf[gnt_ch]};
    tgt_full = stat_full[tgt_idx];
    s00_axis_tready = accept && !gnt_ch;
    s01_axis_tready = accept && gnt_ch;
    rec_last = (rec[cur_ch] == {C_REC_WIDTH{1'b1}});
    done_idx = {cur_ch, wr_buf[cur_ch]};
    set_mask = ((state == W3) && rec_last) ? (4'b0001 << done_idx) : 4'b0000;
  end

  // Next-state: an accepted sample into a non-full buffer starts a record.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !tgt_full) state_nxt = W0;
      W0:      state_nxt = W1;
      W1:      state_nxt = W2;
      W2:      state_nxt = W3;
      W3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // BRAM port: one word per W state, address {ch, buf, rec, word}.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 2'b00;
    bram_addr = '0;
    bram_din  = 16'h0000;
    word      = 2'd0;
    case (state)
      W0: begin word = 2'd0; bram_din = cap_data[15:0];  end
      W1: begin word = 2'd1; bram_din = cap_data[31:16]; end
      W2: begin word = 2'd2; bram_din = cap_ns[15:0];    end
      W3: begin word = 2'd3; bram_din = cap_ns[31:16];   end
      default: ;
    endcase
    if (state != IDLE) begin
      bram_en   = 1'b1;
      bram_we   = 2'b11;
      bram_addr = {cur_ch, wr_buf[cur_ch], rec[cur_ch], word};
    end
  end

  // FSM state register; reset aborts any record in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the granted sample and its timestamp in the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cur_ch     <= 1'b0;
      cap_data   <= 32'h0;
      cap_ns     <= 32'h0;
    end else if (accept) begin
      last_grant <= gnt_ch;
      cur_ch     <= gnt_ch;
      cap_data   <= gnt_ch ? s01_axis_tdata : s00_axis_tdata;
      cap_ns     <= rtc_nanosecond;
    end
  end

  // Record pointers and ping-pong select; cleared while disabled in IDLE.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && !ctrl_enable)) begin
      rec[0] <= '0;
      rec[1] <= '0;
      wr_buf <= 2'b00;
    end else if (state == W3) begin
      rec[cur_ch] <= rec[cur_ch] + C_REC_WIDTH'(1);
      if (rec_last) wr_buf[cur_ch] <= ~wr_buf[cur_ch];
    end
  end

  // Full flags (set beats a coincident release) and the buffer-full pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_full <= 4'b0000;
      irq       <= 1'b0;
    end else begin
      stat_full <= (stat_full & ~ctrl_release) | set_mask;
      irq       <= |set_mask;
    end
  end

  // Saturating per-channel drop counters for samples aimed at a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_drop_cnt0 <= 16'h0000;
      stat_drop_cnt1 <= 16'h0000;
    end else if (accept && tgt_full) begin
      if (!gnt_ch && stat_drop_cnt0 != 16'hFFFF) stat_drop_cnt0 <= stat_drop_cnt0 + 16'h0001;
      if (gnt_ch && stat_drop_cnt1 != 16'hFFFF)  stat_drop_cnt1 <= stat_drop_cnt1 + 16'h0001;
    end
  end

endmodule

// File: tb/tb_coreboard1588_bram_arb.sv
// Directed bench for coreboard1588_bram_arb with C_REC_WIDTH=2
// (4 records per buffer, 6-bit word address {ch, buf, rec[1:0], word[1:0]}).
module tb_coreboard1588_bram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_enable;
  logic [3:0]  ctrl_release;
  logic [31:0] s00_axis_tdata;
  logic        s00_axis_tvalid;
  logic        s00_axis_tready;
  logic [31:0] s01_axis_tdata;
  logic        s01_axis_tvalid;
  logic        s01_axis_tready;
  logic [31:0] rtc_nanosecond;
  logic [5:0]  bram_addr;
  logic        bram_en;
  logic [1:0]  bram_we;
  logic [15:0] bram_din;
  logic        irq;
  logic [3:0]  stat_full;
  logic [15:0] stat_drop_cnt0;
  logic [15:0] stat_drop_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  coreboard1588_bram_arb #(.C_REC_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .ctrl_release(ctrl_release),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tvalid(s01_axis_tvalid),
    .s01_axis_tready(s01_axis_tready),
    .rtc_nanosecond(rtc_nanosecond), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_din(bram_din), .irq(irq), .stat_full(stat_full),
    .stat_drop_cnt0(stat_drop_cnt0), .stat_drop_cnt1(stat_drop_cnt1)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    ctrl_enable = 1'b1;
    ctrl_release = 4'b0000;
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    s00_axis_tdata = 32'h0;
    s01_axis_tdata = 32'h0;
    rtc_nanosecond = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one sample on channel ch and check the resulting record (or drop).
  task automatic do_sample(input int ch, input logic [31:0] data, input logic [31:0] ns,
                           input bit exp_wr, input logic [5:0] exp_base, input bit exp_irq,
                           input bit dis_after);
    bit got;
    logic [15:0] exp_din;
    @(posedge clk); #1;
    if (ch == 0) begin s00_axis_tdata = data; s00_axis_tvalid = 1'b1; end
    else         begin s01_axis_tdata = data; s01_axis_tvalid = 1'b1; end
    rtc_nanosecond = ns;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((ch == 0 && s00_axis_tready) || (ch == 1 && s01_axis_tready)) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL accept_timeout: ch %0d tready never high, required high", ch);
      s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    if (dis_after) ctrl_enable = 1'b0;
    if (!exp_wr) begin
      @(negedge clk);
      n_checks++;
      if (bram_en !== 1'b0) begin
        n_errors++;
        $display("FAIL drop_no_write: bram_en=%b required 0", bram_en);
      end
      return;
    end
    for (int w = 0; w < 4; w++) begin
      case (w)
        0: exp_din = data[15:0];
        1: exp_din = data[31:16];
        2: exp_din = ns[15:0];
        default: exp_din = ns[31:16];
      endcase
      @(negedge clk);
      n_checks++;
      if (bram_en !== 1'b1 || bram_we !== 2'b11 || bram_addr !== exp_base + 6'(w) ||
          bram_din !== exp_din) begin
        n_errors++;
        $display("FAIL record_word%0d: en=%b we=%b addr=%h din=%h required en=1 we=11 addr=%h din=%h",
                 w, bram_en, bram_we, bram_addr, bram_din, exp_base + 6'(w), exp_din);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (irq !== exp_irq) begin
      n_errors++;
      $display("FAIL irq_after_record: irq=%b required %b", irq, exp_irq);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_enable = 1'b1;
    ctrl_release = 4'b0000;
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
    s00_axis_tdata = 32'hDEADBEEF;
    s01_axis_tdata = 32'hCAFEF00D;
    rtc_nanosecond = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s00_axis_tready !== 1'b0 || s01_axis_tready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_tready: %b%b required 00", s01_axis_tready, s00_axis_tready);
    end
    n_checks++;
    if (bram_en !== 1'b0 || bram_we !== 2'b00 || bram_addr !== 6'h00 || bram_din !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_bram: en=%b we=%b addr=%h din=%h required all 0", bram_en, bram_we, bram_addr, bram_din);
    end
    n_checks++;
    if (irq !== 1'b0 || stat_full !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_status: irq=%b full=%b required 0 0000", irq, stat_full);
    end
    n_checks++;
    if (stat_drop_cnt0 !== 16'h0 || stat_drop_cnt1 !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_drops: %h %h required 0 0", stat_drop_cnt0, stat_drop_cnt1);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    do_sample(0, 32'h12345678, 32'h0000ABCD, 1'b1, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [5:0] exp_addr;
    logic [15:0] exp_din;
    bit got;
    apply_reset();
    @(posedge clk); #1;
    s00_axis_tdata = 32'h11112222;
    s01_axis_tdata = 32'h33334444;
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = {1'(k % 2), 1'b0, 2'(k / 2), 2'b00};
      exp_din  = (k % 2 == 0) ? 16'h2222 : 16'h4444;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (s00_axis_tready || s01_axis_tready) begin got = 1'b1; break; end
      end
      n_checks++;
      if (!got || {s01_axis_tready, s00_axis_tready} !== exp_gnt) begin
        n_errors++;
        $display("FAIL rr_grant%0d: tready=%b%b required %b", k, s01_axis_tready, s00_axis_tready, exp_gnt);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (bram_en !== 1'b1 || bram_addr !== exp_addr || bram_din !== exp_din) begin
        n_errors++;
        $display("FAIL rr_write%0d: en=%b addr=%h din=%h required 1 %h %h", k, bram_en, bram_addr, bram_din, exp_addr, exp_din);
      end
    end
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
  endtask

  task automatic test_fill_irq();
    apply_reset();
    for (int k = 0; k < 4; k++)
      do_sample(0, 32'hA0000000 + 32'(k), 32'h00010000 + 32'(k), 1'b1, 6'(k * 4), (k == 3), 1'b0);
    n_checks++;
    if (stat_full !== 4'b0001) begin
      n_errors++;
      $display("FAIL fill_full: stat_full=%b required 0001", stat_full);
    end
    do_sample(0, 32'hB0000000, 32'h00020000, 1'b1, 6'h10, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    for (int k = 1; k < 4; k++)
      do_sample(0, 32'hC0000000 + 32'(k), 32'h00030000 + 32'(k), 1'b1, 6'h10 + 6'(k * 4), (k == 3), 1'b0);
    n_checks++;
    if (stat_full !== 4'b0011) begin
      n_errors++;
      $display("FAIL both_full: stat_full=%b required 0011", stat_full);
    end
    for (int k = 0; k < 3; k++)
      do_sample(0, 32'hD0000000 + 32'(k), 32'h00040000, 1'b0, 6'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stat_drop_cnt0 !== 16'd3 || stat_drop_cnt1 !== 16'd0) begin
      n_errors++;
      $display("FAIL drop_count: cnt0=%0d cnt1=%0d required 3 0", stat_drop_cnt0, stat_drop_cnt1);
    end
  endtask

  task automatic test_release();
    @(posedge clk); #1;
    ctrl_release = 4'b0001;
    @(posedge clk); #1;
    ctrl_release = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (stat_full !== 4'b0010) begin
      n_errors++;
      $display("FAIL release_full: stat_full=%b required 0010", stat_full);
    end
    do_sample(0, 32'hE1E2E3E4, 32'h00050005, 1'b1, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_disable();
    // rec0 is 1 here, so this record lands at 0x04 while disable is pending.
    do_sample(0, 32'hF0F0F0F0, 32'h00060006, 1'b1, 6'h04, 1'b0, 1'b1);
    s00_axis_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (s00_axis_tready !== 1'b0 || bram_en !== 1'b0) begin
        n_errors++;
        $display("FAIL disabled_idle%0d: tready=%b en=%b required 0 0", i, s00_axis_tready, bram_en);
      end
    end
    s00_axis_tvalid = 1'b0;
    n_checks++;
    if (stat_full !== 4'b0010 || stat_drop_cnt0 !== 16'd3) begin
      n_errors++;
      $display("FAIL disabled_retain: full=%b cnt0=%0d required 0010 3", stat_full, stat_drop_cnt0);
    end
    @(posedge clk); #1;
    ctrl_enable = 1'b1;
    do_sample(0, 32'h0BADF00D, 32'h00070007, 1'b1, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit got;
    @(posedge clk); #1;
    s00_axis_tdata = 32'h55667788;
    s00_axis_tvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s00_axis_tready) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL midrst_accept: tready never high, required high");
    end
    @(posedge clk); #1;          // W0
    s00_axis_tvalid = 1'b0;
    @(posedge clk); #1;          // W1
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bram_en !== 1'b0 || bram_we !== 2'b00) begin
      n_errors++;
      $display("FAIL midrst_bram: en=%b we=%b required 0 00", bram_en, bram_we);
    end
    n_checks++;
    if (stat_full !== 4'b0000 || stat_drop_cnt0 !== 16'h0 || stat_drop_cnt1 !== 16'h0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_status: full=%b cnt0=%0d cnt1=%0d irq=%b required 0000 0 0 0",
               stat_full, stat_drop_cnt0, stat_drop_cnt1, irq);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bram_en !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_no_write%0d: en=%b required 0", i, bram_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fill_irq();
    test_drop();
    test_release();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
